// File: rtl/common_cross_buffern_arbiter_if.sv
// Handshake bundle for the N-to-1 buffered arbiter: per-port upstream channels
// plus a single downstream channel tagged with its source port.
interface common_cross_buffern_arbiter_if #(
    parameter int BUFFER_WIDTH = 1,
    parameter int PORT_COUNT   = 4
);
    localparam int SRC_W = $clog2(PORT_COUNT);

    logic [PORT_COUNT*BUFFER_WIDTH-1:0] prev_i_data;
    logic [PORT_COUNT-1:0]              prev_i_valid;
    logic [PORT_COUNT-1:0]              prev_o_ready;
    logic [BUFFER_WIDTH-1:0]            next_o_data;
    logic                               next_o_valid;
    logic                               next_i_ready;
    logic [SRC_W-1:0]                   next_o_source;

    modport slave (
        input  prev_i_data,
        input  prev_i_valid,
        output prev_o_ready,
        output next_o_data,
        output next_o_valid,
        input  next_i_ready,
        output next_o_source
    );

    modport master (
        output prev_i_data,
        output prev_i_valid,
        input  prev_o_ready,
        input  next_o_data,
        input  next_o_valid,
        output next_i_ready,
        input  next_o_source
    );
endinterface

// File: rtl/common_cross_buffern_arbiter.sv
// N-port arbiter with a one-entry skid register per port feeding one registered
// output stage; fixed-priority or round-robin selection.
module common_cross_buffern_arbiter #(
    parameter int BUFFER_WIDTH = 1,
    parameter int PORT_COUNT   = 4,
    parameter int ARBITER_MODE = 0
) (
    input  logic clk,
    input  logic reset,
    common_cross_buffern_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(PORT_COUNT);

    logic [PORT_COUNT-1:0]   held_q;
    logic [BUFFER_WIDTH-1:0] heldData_q [PORT_COUNT];
    logic [BUFFER_WIDTH-1:0] dataOut_q;
    logic                    validOut_q;
    logic [SRC_W-1:0]        source_q;
    logic [SRC_W-1:0]        lastGrant_q;

    logic [PORT_COUNT-1:0]   req;
    logic [BUFFER_WIDTH-1:0] candData [PORT_COUNT];
    logic                    load;
    logic                    grantValid;
    logic [SRC_W-1:0]        grantIdx;
    logic [SRC_W:0]          rrSum;

    assign bus.prev_o_ready  = ~held_q;
    assign bus.next_o_data   = dataOut_q;
    assign bus.next_o_valid  = validOut_q;
    assign bus.next_o_source = source_q;

    assign load = ~validOut_q | bus.next_i_ready;

    // A held beat always takes precedence over the live input of the same port.
    always_comb begin
        for (int i = 0; i < PORT_COUNT; i++) begin
            req[i] = held_q[i] | bus.prev_i_valid[i];
            candData[i] = held_q[i] ? heldData_q[i]
                                    : bus.prev_i_data[i*BUFFER_WIDTH +: BUFFER_WIDTH];
        end
    end

    // Loops run from lowest to highest priority so the last hit is the winner.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        rrSum      = '0;
        if (ARBITER_MODE == 0) begin
            for (int i = PORT_COUNT - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grantValid = 1'b1;
                    grantIdx   = SRC_W'(i);
                end
            end
        end else begin
            for (int k = PORT_COUNT; k >= 1; k--) begin
                rrSum = {1'b0, lastGrant_q} + (SRC_W+1)'(k);
                if (rrSum >= (SRC_W+1)'(PORT_COUNT)) begin
                    rrSum = rrSum - (SRC_W+1)'(PORT_COUNT);
                end
                if (req[rrSum[SRC_W-1:0]]) begin
                    grantValid = 1'b1;
                    grantIdx   = rrSum[SRC_W-1:0];
                end
            end
        end
        if (!load) begin
            grantValid = 1'b0;
        end
    end

    // Losing requesters park their beat; a granted live beat bypasses the hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_q <= '0;
            for (int i = 0; i < PORT_COUNT; i++) begin
                heldData_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PORT_COUNT; i++) begin
                if (grantValid && (grantIdx == SRC_W'(i))) begin
                    held_q[i] <= 1'b0;
                end else if (!held_q[i] && bus.prev_i_valid[i]) begin
                    held_q[i]     <= 1'b1;
                    heldData_q[i] <= bus.prev_i_data[i*BUFFER_WIDTH +: BUFFER_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataOut_q   <= '0;
            validOut_q  <= 1'b0;
            source_q    <= '0;
            lastGrant_q <= SRC_W'(PORT_COUNT - 1);
        end else if (load) begin
            if (grantValid) begin
                dataOut_q   <= candData[grantIdx];
                validOut_q  <= 1'b1;
                source_q    <= grantIdx;
                lastGrant_q <= grantIdx;
            end else begin
                validOut_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_common_cross_buffern_arbiter.sv
// Scoreboard bench: one fixed-priority and one round-robin instance share a clock;
// expected {source,data} pairs are queued at stimulus time and popped on output.
module tb_common_cross_buffern_arbiter;
    localparam int BW = 8;
    localparam int PC = 4;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    logic [31:0] sbF [$];
    logic [31:0] sbR [$];

    common_cross_buffern_arbiter_if #(.BUFFER_WIDTH(BW), .PORT_COUNT(PC)) busF ();
    common_cross_buffern_arbiter_if #(.BUFFER_WIDTH(BW), .PORT_COUNT(PC)) busR ();

    common_cross_buffern_arbiter #(.BUFFER_WIDTH(BW), .PORT_COUNT(PC), .ARBITER_MODE(0)) dutF (
        .clk   (clk),
        .reset (reset),
        .bus   (busF)
    );

    common_cross_buffern_arbiter #(.BUFFER_WIDTH(BW), .PORT_COUNT(PC), .ARBITER_MODE(1)) dutR (
        .clk   (clk),
        .reset (reset),
        .bus   (busR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit toR, input logic [PC-1:0] valid, input logic [8*PC-1:0] data);
        if (toR) begin
            busR.prev_i_valid = valid;
            busR.prev_i_data  = data;
        end else begin
            busF.prev_i_valid = valid;
            busF.prev_i_data  = data;
        end
    endtask

    // Output monitors sample on the falling edge, away from the capture edge.
    always @(negedge clk) begin
        if (reset && busF.next_o_valid && busF.next_i_ready) begin
            if (sbF.size() == 0) begin
                checkOutput("unexpectedF", 32'(busF.next_o_valid), 32'd0);
            end else begin
                checkOutput("outF", {22'd0, busF.next_o_source, busF.next_o_data}, sbF.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset && busR.next_o_valid && busR.next_i_ready) begin
            if (sbR.size() == 0) begin
                checkOutput("unexpectedR", 32'(busR.next_o_valid), 32'd0);
            end else begin
                checkOutput("outR", {22'd0, busR.next_o_source, busR.next_o_data}, sbR.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] expBeat(input int src, input logic [7:0] data);
        return {22'd0, 2'(src), data};
    endfunction

    initial begin
        logic [8*PC-1:0] d;
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        busF.next_i_ready = 1'b0;
        busR.next_i_ready = 1'b0;
        applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b1, '0, '0);

        // Reset with random traffic
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'($urandom), 32'($urandom));
            applyStimulus(1'b1, 4'($urandom), 32'($urandom));
            busF.next_i_ready = 1'($urandom);
            busR.next_i_ready = 1'($urandom);
            stepCycle();
        end
        checkOutput("rstValidF", 32'(busF.next_o_valid), 32'd0);
        checkOutput("rstValidR", 32'(busR.next_o_valid), 32'd0);
        checkOutput("rstReadyF", 32'(busF.prev_o_ready), 32'hF);
        checkOutput("rstReadyR", 32'(busR.prev_o_ready), 32'hF);
        checkOutput("rstSrcF", 32'(busF.next_o_source), 32'd0);
        checkOutput("rstSrcR", 32'(busR.next_o_source), 32'd0);
        applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b1, '0, '0);
        busF.next_i_ready = 1'b1;
        busR.next_i_ready = 1'b1;
        reset = 1'b1;
        stepCycle();
        checkOutput("relValidF", 32'(busF.next_o_valid), 32'd0);
        checkOutput("relValidR", 32'(busR.next_o_valid), 32'd0);

        // Fixed-priority contention
        d = 32'h13121110;
        for (int i = 0; i < PC; i++) sbF.push_back(expBeat(i, 8'(8'h10 + i)));
        applyStimulus(1'b0, 4'hF, d);
        stepCycle();
        applyStimulus(1'b0, 4'h0, '0);
        checkOutput("contReady0", 32'(busF.prev_o_ready), 32'b0001);
        for (int k = 1; k < PC; k++) begin
            stepCycle();
            checkOutput("contReady", 32'(busF.prev_o_ready), 32'((1 << (k + 1)) - 1));
        end
        repeat (2) stepCycle();

        // Round-robin rotation over eight grants
        for (int n = 0; n < 8; n++) sbR.push_back(expBeat(n % PC, 8'(8'h20 + (n % PC))));
        applyStimulus(1'b1, 4'hF, 32'h23222120);
        repeat (5) stepCycle();
        applyStimulus(1'b1, 4'h0, '0);
        repeat (5) stepCycle();

        // Backpressure on the fixed-priority instance
        busF.next_i_ready = 1'b0;
        sbF.push_back(expBeat(2, 8'hA5));
        sbF.push_back(expBeat(2, 8'hA6));
        applyStimulus(1'b0, 4'b0100, 32'h00A50000);
        stepCycle();
        applyStimulus(1'b0, 4'b0100, 32'h00A60000);
        stepCycle();
        applyStimulus(1'b0, 4'b0000, '0);
        checkOutput("bpReady", 32'(busF.prev_o_ready), 32'b1011);
        for (int c = 0; c < 3; c++) begin
            checkOutput("bpValid", 32'(busF.next_o_valid), 32'd1);
            checkOutput("bpData", 32'(busF.next_o_data), 32'hA5);
            checkOutput("bpSrc", 32'(busF.next_o_source), 32'd2);
            stepCycle();
        end
        busF.next_i_ready = 1'b1;
        repeat (4) stepCycle();

        // Single-beat bypass while idle
        sbF.push_back(expBeat(1, 8'h3C));
        applyStimulus(1'b0, 4'b0010, 32'h00003C00);
        stepCycle();
        applyStimulus(1'b0, 4'b0000, '0);
        checkOutput("bypValid", 32'(busF.next_o_valid), 32'd1);
        checkOutput("bypData", 32'(busF.next_o_data), 32'h3C);
        checkOutput("bypSrc", 32'(busF.next_o_source), 32'd1);
        checkOutput("bypReady", 32'(busF.prev_o_ready), 32'hF);
        repeat (3) stepCycle();

        // Asynchronous reset with held entries and a pending output
        busR.next_i_ready = 1'b0;
        applyStimulus(1'b1, 4'hF, 32'h33323130);
        stepCycle();
        applyStimulus(1'b1, 4'h0, '0);
        checkOutput("preRstValidR", 32'(busR.next_o_valid), 32'd1);
        checkOutput("preRstReadyR", 32'(busR.prev_o_ready), 32'b0001);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midRstValidR", 32'(busR.next_o_valid), 32'd0);
        checkOutput("midRstReadyR", 32'(busR.prev_o_ready), 32'hF);
        checkOutput("midRstSrcR", 32'(busR.next_o_source), 32'd0);
        stepCycle();
        reset = 1'b1;
        busR.next_i_ready = 1'b1;
        stepCycle();
        checkOutput("postRstValidR", 32'(busR.next_o_valid), 32'd0);
        for (int i = 0; i < PC; i++) sbR.push_back(expBeat(i, 8'(8'h40 + i)));
        applyStimulus(1'b1, 4'hF, 32'h43424140);
        stepCycle();
        applyStimulus(1'b1, 4'h0, '0);
        repeat (6) stepCycle();

        checkOutput("drainF", 32'(sbF.size()), 32'd0);
        checkOutput("drainR", 32'(sbR.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
